// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single memory port with d-priority and a starvation bound for i.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic grant_i, grant_d;
  always_comb begin
    grant_i = i_req && (!d_req || streak == SW'(STARVE_LIMIT));
    grant_d = d_req && !grant_i;
  end
  // streak cannot overflow: at the limit the i side wins, which clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      streak  <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state   <= BUSY_I;
            streak  <= '0;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= 4'hF;
          end else if (grant_d) begin
            state   <= BUSY_D;
            streak  <= i_req ? streak + 1'b1 : '0;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
          end
        end
        BUSY_I: begin
          if (m_ready) begin
            state   <= DONE;
            m_req   <= 1'b0;
            i_rdata <= m_rdata;
            i_ready <= 1'b1;
          end
        end
        BUSY_D: begin
          if (m_ready) begin
            state   <= DONE;
            m_req   <= 1'b0;
            d_rdata <= m_rdata;
            d_ready <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
